// File: rtl/bsg_print_stat_snoop_fifo.sv
// Passive snoop of print_stat stores on several request channels. Hits are stamped
// with the global cycle counter and funnelled round-robin into one FWFT FIFO.
module bsg_print_stat_snoop_fifo #(
  parameter int num_links_p = 1,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32,
  parameter int ctr_width_p = 64,
  parameter int els_p = 16,
  parameter logic [addr_width_p-1:0] print_stat_epa_p = 'h0D0C,
  parameter int drop_width_p = 16,
  localparam int chan_width_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                en_i,
  input  logic [ctr_width_p-1:0]              ctr_i,
  input  logic [num_links_p-1:0]              v_i,
  input  logic [num_links_p-1:0]              ready_i,
  input  logic [num_links_p-1:0]              store_i,
  input  logic [num_links_p*addr_width_p-1:0] addr_i,
  input  logic [num_links_p*data_width_p-1:0] data_i,
  output logic                                v_o,
  output logic [data_width_p-1:0]             tag_o,
  output logic [ctr_width_p-1:0]              stamp_o,
  output logic [chan_width_lp-1:0]            chan_o,
  input  logic                                yumi_i,
  output logic [drop_width_p-1:0]             drop_cnt_o,
  output logic                                overflow_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [num_links_p-1:0]   hit, drop, grant;
  logic [num_links_p-1:0]   occ_q, occ_d;
  logic [data_width_p-1:0]  tag_q [num_links_p];
  logic [data_width_p-1:0]  tag_d [num_links_p];
  logic [ctr_width_p-1:0]   stamp_q [num_links_p];
  logic [ctr_width_p-1:0]   stamp_d [num_links_p];

  logic [chan_width_lp-1:0] rr_ptr_q, rr_ptr_d, grant_idx;
  logic                     grant_v, can_push, push, pop;

  logic [ptr_width_lp-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
  logic [drop_width_p-1:0]  drop_cnt_q, drop_cnt_d;
  logic                     overflow_q, overflow_d;

  logic [data_width_p-1:0]  mem_tag   [els_p];
  logic [ctr_width_p-1:0]   mem_stamp [els_p];
  logic [chan_width_lp-1:0] mem_chan  [els_p];

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < num_links_p; k++) begin
      hit[k] = en_i & v_i[k] & ready_i[k] & store_i[k]
             & (addr_i[k*addr_width_p +: addr_width_p] == print_stat_epa_p);
    end
  end

  // A full FIFO can still take a push in the cycle its head is popped.
  assign can_push = (cnt_q != cnt_width_lp'(els_p)) | yumi_i;

  always_comb begin
    int idx;
    grant     = '0;
    grant_v   = 1'b0;
    grant_idx = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int i = 0; i < num_links_p; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= num_links_p) idx = idx - num_links_p;
      if (!grant_v && can_push && occ_q[idx]) begin
        grant_v    = 1'b1;
        grant_idx  = chan_width_lp'(idx);
        grant[idx] = 1'b1;
      end
    end
    if (grant_v) begin
      rr_ptr_d = (grant_idx == chan_width_lp'(num_links_p - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    for (int k = 0; k < num_links_p; k++) begin
      drop[k]    = hit[k] & occ_q[k] & ~grant[k];
      occ_d[k]   = occ_q[k] & ~grant[k];
      tag_d[k]   = tag_q[k];
      stamp_d[k] = stamp_q[k];
      if (hit[k] && !drop[k]) begin
        occ_d[k]   = 1'b1;
        tag_d[k]   = data_i[k*data_width_p +: data_width_p];
        stamp_d[k] = ctr_i;
      end
      if (drop[k] && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + 1'b1;
    end
    overflow_d = overflow_q | (|drop);
  end

  always_comb begin
    push     = grant_v;
    pop      = yumi_i & (cnt_q != '0);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_q      <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: payload storage is not reset; occ_q and cnt_q alone decide what is valid.
  always_ff @(posedge clk_i) begin
    tag_q   <= tag_d;
    stamp_q <= stamp_d;
    if (push) begin
      mem_tag[wr_ptr_q]   <= tag_q[grant_idx];
      mem_stamp[wr_ptr_q] <= stamp_q[grant_idx];
      mem_chan[wr_ptr_q]  <= grant_idx;
    end
  end

  assign v_o        = (cnt_q != '0);
  assign tag_o      = mem_tag[rd_ptr_q];
  assign stamp_o    = mem_stamp[rd_ptr_q];
  assign chan_o     = mem_chan[rd_ptr_q];
  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o)) else $error("yumi_i asserted while v_o=0");
    end
  end

endmodule

// File: tb/tb_bsg_print_stat_snoop_fifo.sv
// Directed bench for bsg_print_stat_snoop_fifo: 4 links, 4-deep FIFO.
// Inputs change and outputs are sampled on the falling edge.
module tb_bsg_print_stat_snoop_fifo;

  localparam int NL  = 4;
  localparam int AW  = 28;
  localparam int DW  = 32;
  localparam int CW  = 64;
  localparam int ELS = 4;
  localparam int DRW = 16;

  logic             clk, reset_i, en_i, yumi_i;
  logic [CW-1:0]    ctr_i;
  logic [NL-1:0]    v_i, ready_i, store_i;
  logic [NL*AW-1:0] addr_i;
  logic [NL*DW-1:0] data_i;
  logic             v_o, overflow_o;
  logic [DW-1:0]    tag_o;
  logic [CW-1:0]    stamp_o;
  logic [1:0]       chan_o;
  logic [DRW-1:0]   drop_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  bsg_print_stat_snoop_fifo #(
    .num_links_p(NL), .addr_width_p(AW), .data_width_p(DW), .ctr_width_p(CW),
    .els_p(ELS), .print_stat_epa_p(28'h0D0C), .drop_width_p(DRW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .ctr_i(ctr_i),
    .v_i(v_i), .ready_i(ready_i), .store_i(store_i), .addr_i(addr_i), .data_i(data_i),
    .v_o(v_o), .tag_o(tag_o), .stamp_o(stamp_o), .chan_o(chan_o), .yumi_i(yumi_i),
    .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    v_i = '0; ready_i = '0; store_i = '0; addr_i = '0; data_i = '0;
  endtask

  task automatic set_hit(input int k, input logic [DW-1:0] tag);
    v_i[k] = 1'b1; ready_i[k] = 1'b1; store_i[k] = 1'b1;
    addr_i[k*AW +: AW] = 28'h0D0C;
    data_i[k*DW +: DW] = tag;
  endtask

  task automatic do_reset();
    idle();
    yumi_i = 1'b0;
    reset_i = 1'b1;
    cyc(); cyc();
    reset_i = 1'b0;
  endtask

  initial begin
    int h, p;
    reset_i = 1'b1; en_i = 1'b1; yumi_i = 1'b0; ctr_i = '0;
    idle();
    cyc();
    do_reset();

    // reset state
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);

    // T1 single hit, two-cycle latency
    set_hit(0, 5); ctr_i = 100; cyc();
    idle(); ctr_i = 101;
    check("t1_v_t1", 64'(v_o), 64'd0);
    cyc();
    check("t1_v_t2", 64'(v_o), 64'd1);
    check("t1_tag", 64'(tag_o), 64'd5);
    check("t1_stamp", stamp_o, 64'd100);
    check("t1_chan", 64'(chan_o), 64'd0);
    yumi_i = 1'b1; cyc(); yumi_i = 1'b0;
    check("t1_v_pop", 64'(v_o), 64'd0);

    // T2 contention on all four links
    do_reset();
    for (int k = 0; k < NL; k++) set_hit(k, DW'(k + 1));
    ctr_i = 200; cyc();
    idle(); ctr_i = 201; cyc();
    for (int i = 0; i < NL; i++) begin
      check("t2_v", 64'(v_o), 64'd1);
      check("t2_chan", 64'(chan_o), 64'(i));
      check("t2_tag", 64'(tag_o), 64'(i + 1));
      check("t2_stamp", stamp_o, 64'd200);
      yumi_i = 1'b1; cyc(); yumi_i = 1'b0;
    end
    check("t2_empty", 64'(v_o), 64'd0);
    check("t2_drop", 64'(drop_cnt_o), 64'd0);

    // T5 filters: wrong EPA, load, no ready, capture disabled
    idle(); set_hit(2, 50); addr_i[2*AW +: AW] = 28'h0D0D; cyc();
    idle(); set_hit(2, 51); store_i[2] = 1'b0; cyc();
    idle(); set_hit(2, 52); ready_i[2] = 1'b0; cyc();
    idle(); set_hit(2, 53); en_i = 1'b0; cyc();
    idle(); en_i = 1'b1; cyc(); cyc();
    check("t5_v", 64'(v_o), 64'd0);
    check("t5_drop", 64'(drop_cnt_o), 64'd0);
    check("t5_ovf", 64'(overflow_o), 64'd0);

    // T4 ten hits spaced two cycles, continuous popping
    h = 0; p = 0;
    for (int s = 0; s < 30; s++) begin
      idle();
      if ((s % 2 == 0) && (h < 10)) begin
        set_hit(h % NL, DW'(40 + h));
        h++;
      end
      ctr_i = CW'(400 + s);
      if (v_o) begin
        check("t4_tag", 64'(tag_o), 64'(40 + p));
        check("t4_chan", 64'(chan_o), 64'(p % NL));
        yumi_i = 1'b1;
        p++;
      end else begin
        yumi_i = 1'b0;
      end
      cyc();
    end
    yumi_i = 1'b0; idle();
    check("t4_pops", 64'(p), 64'd10);
    check("t4_drop", 64'(drop_cnt_o), 64'd0);

    // T3 fill FIFO from ch0, then ch1 collides while full
    for (int i = 0; i < 4; i++) begin
      idle(); set_hit(0, DW'(10 + i)); ctr_i = CW'(300 + i); cyc();
    end
    idle(); ctr_i = 304; cyc();
    check("t3_full_v", 64'(v_o), 64'd1);
    idle(); set_hit(1, 20); ctr_i = 305; cyc();
    check("t3_no_drop_yet", 64'(drop_cnt_o), 64'd0);
    idle(); set_hit(1, 21); ctr_i = 306; cyc();
    idle();
    check("t3_drop", 64'(drop_cnt_o), 64'd1);
    check("t3_ovf", 64'(overflow_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("t3_v", 64'(v_o), 64'd1);
      check("t3_tag", 64'(tag_o), (i < 4) ? 64'(10 + i) : 64'd20);
      check("t3_chan", 64'(chan_o), (i < 4) ? 64'd0 : 64'd1);
      check("t3_stamp", stamp_o, (i < 4) ? 64'(300 + i) : 64'd305);
      yumi_i = 1'b1; cyc(); yumi_i = 1'b0;
    end
    check("t3_empty", 64'(v_o), 64'd0);
    check("t3_drop_hold", 64'(drop_cnt_o), 64'd1);

    // T6 reset with entries queued and held
    for (int k = 0; k < NL; k++) set_hit(k, DW'(60 + k));
    ctr_i = 800; cyc();
    idle(); cyc(); cyc();
    set_hit(0, 64); cyc();
    idle();
    check("t6_busy", 64'(v_o), 64'd1);
    reset_i = 1'b1; set_hit(1, 70); cyc();
    reset_i = 1'b0; idle();
    check("t6_v", 64'(v_o), 64'd0);
    check("t6_drop", 64'(drop_cnt_o), 64'd0);
    check("t6_ovf", 64'(overflow_o), 64'd0);
    cyc(); cyc(); cyc();
    check("t6_discarded", 64'(v_o), 64'd0);
    set_hit(2, 77); ctr_i = 900; cyc();
    idle(); ctr_i = 901; cyc();
    check("t6_after_v", 64'(v_o), 64'd1);
    check("t6_after_tag", 64'(tag_o), 64'd77);
    check("t6_after_stamp", stamp_o, 64'd900);
    check("t6_after_chan", 64'(chan_o), 64'd2);
    yumi_i = 1'b1; cyc(); yumi_i = 1'b0;
    check("t6_after_empty", 64'(v_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
